// File: rtl/huff_pkg.sv
// Shared constants, component encoding and scheduler state enumeration for the
// Huffman MCU scheduler and its DC predictor.
package huff_pkg;

  localparam int DC_W   = 10;
  localparam int DIFF_W = 11;

  localparam logic [2:0] BLK_Y0 = 3'd0;
  localparam logic [2:0] BLK_Y1 = 3'd1;
  localparam logic [2:0] BLK_Y2 = 3'd2;
  localparam logic [2:0] BLK_Y3 = 3'd3;
  localparam logic [2:0] BLK_CB = 3'd4;
  localparam logic [2:0] BLK_CR = 3'd5;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic logic [1:0] comp_of(input logic [2:0] blk);
    if (blk == BLK_CB) return COMP_CB;
    if (blk == BLK_CR) return COMP_CR;
    return COMP_Y;
  endfunction

endpackage

// File: rtl/huff_dc_predictor.sv
// Three per-component DC predictors (Y, Cb, Cr) with bulk clear, single-entry
// write, and an 11-bit sign-extended difference against the selected entry.
module huff_dc_predictor
  import huff_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [1:0]        comp,
  input  logic [DC_W-1:0]   dc_in,
  output logic [DIFF_W-1:0] diff
);

  logic [DC_W-1:0] pred [3];
  logic [DC_W-1:0] pred_sel;

  always_comb begin
    pred_sel = pred[0];
    case (comp)
      COMP_CB: pred_sel = pred[1];
      COMP_CR: pred_sel = pred[2];
      default: pred_sel = pred[0];
    endcase
  end

  // Both operands are sign-extended so the full -1023..+1023 range fits without wrap.
  assign diff = {dc_in[DC_W-1], dc_in} - {pred_sel[DC_W-1], pred_sel};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) pred[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 3; i++) pred[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 3; i++)
        if (comp == 2'(i)) pred[i] <= dc_in;
    end
  end

endmodule

// File: rtl/huffman_mcu_scheduler.sv
// Walks the blocks of one MCU through the Huffman encoder, producing DC
// differences; optional watchdog enabled by HUFF_SCHED_WATCHDOG_EN.
module huffman_mcu_scheduler
  import huff_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mcu_start,
  input  logic              mode_420,
  input  logic              frame_start,
  input  logic [DC_W-1:0]   blk_dc,
  input  logic              huff_active,
  input  logic              huff_end,
  output logic              mcu_busy,
  output logic              mcu_done,
  output logic [2:0]        blk_sel,
  output logic              huff_start,
  output logic              huff_is_luminance,
  output logic [DIFF_W-1:0] dc_diff,
  output logic [2:0]        eob_count,
  output logic              sched_error,
  output state_t            dbg_state
);

  state_t            state, state_next;
  logic              mode_q;
  logic              huff_end_q;
  logic              accept;
  logic              timeout;
  logic [DIFF_W-1:0] diff;

  assign accept = (state == S_IDLE) && mcu_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (mcu_start) state_next = S_LOAD;
      S_LOAD:      state_next = S_START;
      S_START:     state_next = S_WAIT_ACT;
      S_WAIT_ACT:  if (huff_active) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!huff_active) state_next = S_NEXT;
      S_NEXT:      state_next = (blk_sel == BLK_CR) ? S_DONE : S_LOAD;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_DONE;
  end

  assign huff_start        = (state == S_START);
  assign mcu_done          = (state == S_DONE);
  assign mcu_busy          = (state != S_IDLE) && (state != S_DONE);
  assign huff_is_luminance = mcu_busy && (blk_sel < BLK_CB);
  assign dbg_state         = state;

  huff_dc_predictor u_pred (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept && frame_start),
    .wr_en   (state == S_LOAD),
    .comp    (comp_of(blk_sel)),
    .dc_in   (blk_dc),
    .diff    (diff)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= 1'b0;
      blk_sel    <= BLK_Y0;
      eob_count  <= '0;
      dc_diff    <= '0;
      huff_end_q <= 1'b0;
    end else begin
      huff_end_q <= huff_end;
      if (accept) begin
        mode_q    <= mode_420;
        blk_sel   <= BLK_Y0;
        eob_count <= '0;
      end
      if (state == S_LOAD) dc_diff <= diff;
      // 4:4:4 jumps from Y0 straight to Cb; from Cb onward both modes step by one.
      if (state == S_NEXT && blk_sel != BLK_CR)
        blk_sel <= (mode_q || blk_sel >= BLK_CB) ? blk_sel + 3'd1 : BLK_CB;
      if (state == S_WAIT_DONE && huff_active && huff_end && !huff_end_q
          && eob_count != 3'd6)
        eob_count <= eob_count + 3'd1;
    end
  end

`ifdef HUFF_SCHED_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        in_wait;

  assign in_wait = (state == S_WAIT_ACT) || (state == S_WAIT_DONE);
  assign timeout = in_wait && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      sched_error <= 1'b0;
    end else begin
      if (!in_wait || state_next != state) wd_cnt <= '0;
      else                                 wd_cnt <= wd_cnt + 16'd1;
      if (timeout) sched_error <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign sched_error = 1'b0;
`endif

endmodule
